ram_dump_tx: RTL and testbench
==============================

# ram_dump_tx

Parametrised RAM-to-PC dump engine. On a start pulse it walks an address range of a synchronous RAM, reads each word of `DATA_W` bits, and serialises it byte by byte to a UART byte transmitter using the single-pulse `tx_int` / `tx_ok` handshake. It sits between the correlator result RAM and the `uart_tx` instance. It generalises the fixed 32-bit, 16-bit-address sender with:
- configurable word width, address width and RAM read latency
- selectable byte order
- range wrap-around and an abort input
- an optional trailing checksum

## Interface
- `DATA_W`, 32: RAM word width; a multiple of 8, from 8 to 128.
- `ADDR_W`, 16: address width.
- `RD_LAT`, 1: RAM read latency in cycles, 1 to 4.
- `MSB_FIRST`, 0: 0 sends byte [7:0] first; 1 sends the top byte first.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  main clock, 100 MHz.
- `rst`  in  1  asynchronous active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `abort`  in  1  stops the dump at the next clock edge.
- `start_addr`  in  ADDR_W  first address.
- `end_addr`  in  ADDR_W  last address, inclusive.
- `rd_en`  out  1  one-cycle RAM read strobe.
- `rd_addr`  out  ADDR_W  RAM address.
- `rd_data`  in  DATA_W  RAM data, valid RD_LAT cycles after `rd_en`.
- `tx_byte`  out  8  byte to the UART.
- `tx_int`  out  1  one-cycle pulse that starts a UART byte.
- `tx_ok`  in  1  one-cycle pulse when the UART has finished the byte.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse when the dump completes normally.

## Operation
- States: IDLE, READ, CAPTURE, SEND, WAIT, NEXT, CSUM_SEND, CSUM_WAIT, DONE.
- IDLE:
  - on `start`, latch `start_addr` into `rd_addr` and `end_addr` into an end register, clear the checksum, go to READ.
  - address inputs are ignored at all other times.
- READ: assert `rd_en` for one cycle, then count RD_LAT cycles and go to CAPTURE.
- CAPTURE: load `rd_data` into a DATA_W shift register and set the byte counter to DATA_W/8.
  - After capture the RAM output may change freely.
- SEND: present the current byte on `tx_byte`, pulse `tx_int`, go to WAIT.
- WAIT: hold `tx_byte`. On `tx_ok`:
  - shift the register by 8 (direction set by MSB_FIRST) and decrement the counter
  - counter not yet zero: go to SEND
  - counter zero: go to NEXT.
- NEXT:
  - `rd_addr` == end register: go to CSUM_SEND if the checksum is enabled, otherwise DONE.
  - otherwise: `rd_addr` <= `rd_addr` + 1 (modulo 2^ADDR_W), go to READ.
- Wrap-around: if `end_addr` < `start_addr`, the walk passes through 2^ADDR_W−1 to 0. The word count is (end − start + 1) mod 2^ADDR_W. If that count is 0 (end = start − 1), all 2^ADDR_W words are sent.
- `start_addr` == `end_addr`: exactly one word is sent.
- DONE: pulse `done` for one cycle, go to IDLE.
- `abort`, in any non-IDLE state:
  - go to IDLE at the next edge; `done` is not pulsed
  - `tx_int` is never asserted after abort
  - a byte already in flight finishes inside the UART; its `tx_ok` is ignored.
- `tx_ok` outside WAIT or CSUM_WAIT is ignored.
- `start` while busy is ignored.

## Timing
- Reset values: all outputs are 0 and the state is IDLE.
- `rst` mid-dump returns the block to IDLE immediately (asynchronously).
- `start` to the first `rd_en`: 1 cycle.
- `rd_en` to CAPTURE: RD_LAT cycles.
- CAPTURE to the first `tx_int`: 1 cycle.
- `tx_ok` to the next `tx_int` within a word: 1 cycle.
- Last `tx_ok` of a word to the next `rd_en`: 2 cycles (NEXT, then READ).
- `tx_byte` is registered and stable from the SEND cycle until `tx_ok` is accepted.
- `busy` falls in the same cycle as the `done` pulse's following edge: IDLE is entered one cycle after DONE.

## Configuration
- `DUMP_CHECKSUM_EN` defined:
  - an 8-bit running sum, modulo 256, of every data byte accepted by `tx_ok` is kept
  - after the last word, CSUM_SEND sends that sum as one extra byte, then CSUM_WAIT waits for `tx_ok`, then DONE.
- Not defined: the CSUM states and the sum register are absent, and NEXT goes straight to DONE.

## Structure
- The shared package holds:
  - the state enumeration
  - the DATA_W % 8 == 0 check
  - BYTES = DATA_W/8
  - the byte-counter width, $clog2(BYTES+1).
- One natural sub-module, `word_byte_shifter`: parallel load, shift by 8 in either direction, and a remaining-bytes count.
- The top FSM, address counter and checksum stay in `ram_dump_tx`.

## Test plan
- DATA_W=32, MSB_FIRST=0, range 0x0010..0x0011, RAM[0x10]=0x44332211, RAM[0x11]=0xDDCCBBAA, UART model returns `tx_ok` 10 cycles after `tx_int` -> bytes 11 22 33 44 AA BB CC DD, then a single `done`.
- MSB_FIRST=1, DATA_W=48, one word 0x0102_0304_0506 -> bytes 01 02 03 04 05 06; `start_addr` == `end_addr` gives exactly one `rd_en`.
- ADDR_W=4, range 0xE..0x1 -> `rd_addr` sequence E, F, 0, 1, then `done`.
- Abort 3 cycles after the second `tx_int` -> no further `tx_int`, no `done`, `busy`=0 within 1 cycle; a later `start` restarts cleanly.
- RD_LAT=3, with `rd_data` changed 1 cycle after CAPTURE -> the transmitted bytes match the captured value.
- `DUMP_CHECKSUM_EN` defined, word 0x000000FF then 0x00000002 -> extra final byte 0x01.

Source files
------------

// File: rtl/ram_dump_tx_pkg.sv
// ram_dump_tx_pkg: shared types and width helpers for the RAM dump engine.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: FSM state enumeration, DATA_W legality check, bytes-per-word and
// byte-counter width helpers. Honours DUMP_CHECKSUM_EN (adds the CSUM states).
package ram_dump_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_SEND,
    ST_WAIT,
    ST_NEXT,
`ifdef DUMP_CHECKSUM_EN
    ST_CSUM_SEND,
    ST_CSUM_WAIT,
`endif
    ST_DONE
  } state_t;

  // Word width must be whole bytes, 8..128 bits.
  function automatic bit data_w_ok(input int w);
    return (w % 8 == 0) && (w >= 8) && (w <= 128);
  endfunction

  // BYTES = DATA_W / 8
  function automatic int bytes_of(input int w);
    return w / 8;
  endfunction

  // Byte counter must hold BYTES itself, hence BYTES+1 codes.
  function automatic int cnt_w_of(input int w);
    return $clog2(w / 8 + 1);
  endfunction

endpackage

// File: rtl/word_byte_shifter.sv
// word_byte_shifter: holds one RAM word and hands it out a byte at a time.
// Latency: load and shift take effect at the next clk edge; cur_byte is a register slice.
// Backpressure: none internally; the owner decides when to shift.
// Ports: clk/rst, load + load_data (parallel load, count := BYTES),
//        shift (move next byte into place, count - 1), cur_byte, remaining.
module word_byte_shifter
  import ram_dump_tx_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = cnt_w_of(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  output logic [7:0]        cur_byte,
  output logic [CNT_W-1:0]  remaining
);

  localparam logic [CNT_W-1:0] BYTES_C = CNT_W'(bytes_of(DATA_W));

  logic [DATA_W-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr        <= '0;
      remaining <= '0;
    end else if (load) begin
      sr        <= load_data;
      remaining <= BYTES_C;
    end else if (shift) begin
      // The byte just sent leaves from the end cur_byte looks at.
      sr <= MSB_FIRST ? (sr << 8) : (sr >> 8);
      if (remaining != '0) remaining <= remaining - CNT_W'(1);
    end
  end

  if (MSB_FIRST) begin : g_msb
    assign cur_byte = sr[DATA_W-1 -: 8];
  end else begin : g_lsb
    assign cur_byte = sr[7:0];
  end

endmodule

// File: rtl/ram_dump_tx.sv
// ram_dump_tx: walks start_addr..end_addr (wrapping) of a sync RAM and streams words to a UART byte by byte.
// Latency: start->rd_en 1, rd_en->capture RD_LAT, capture->tx_int 1, tx_ok->next tx_int 1, last tx_ok->rd_en 2.
// Backpressure: one byte in flight; waits for tx_ok before the next; abort returns to IDLE at the next edge.
// Ports: start/abort/start_addr/end_addr control, rd_en/rd_addr/rd_data RAM port,
//        tx_byte/tx_int/tx_ok UART handshake, busy/done status.
// Option: DUMP_CHECKSUM_EN appends one byte holding the mod-256 sum of all data bytes.
module ram_dump_tx
  import ram_dump_tx_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int RD_LAT    = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_byte,
  output logic              tx_int,
  input  logic              tx_ok,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = cnt_w_of(DATA_W);
  localparam int LAT_W = 2;  // RD_LAT is 1..4, counted 0..RD_LAT-1
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("ram_dump_tx: DATA_W must be a multiple of 8 between 8 and 128");
  end

  state_t              state;
  logic [ADDR_W-1:0]   end_reg;
  logic [LAT_W-1:0]    lat_cnt;
  logic [CNT_W-1:0]    remaining;
  logic                load_en;
  logic                shift_en;
  logic [DATA_W-1:0]   load_data;

`ifdef DUMP_CHECKSUM_EN
  logic [7:0]          csum;
  logic [DATA_W-1:0]   csum_word;
  // Park the sum where cur_byte reads, so the checksum goes out through the shifter.
  assign csum_word = MSB_FIRST ? (DATA_W'(csum) << (DATA_W - 8)) : DATA_W'(csum);
`endif

  assign busy = (state != ST_IDLE);

  always_comb begin
    load_en   = 1'b0;
    shift_en  = 1'b0;
    load_data = rd_data;
    if (!abort) begin
      case (state)
        ST_CAPTURE: load_en = 1'b1;
        ST_WAIT:    shift_en = tx_ok;
`ifdef DUMP_CHECKSUM_EN
        ST_NEXT: begin
          if (rd_addr == end_reg) begin
            load_en   = 1'b1;
            load_data = csum_word;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  word_byte_shifter #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST),
    .CNT_W     (CNT_W)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load_en),
    .load_data (load_data),
    .shift     (shift_en),
    .cur_byte  (tx_byte),
    .remaining (remaining)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rd_addr <= '0;
      end_reg <= '0;
      lat_cnt <= '0;
      rd_en   <= 1'b0;
      tx_int  <= 1'b0;
      done    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      // All three strobes are single-cycle; they are raised on the edge entering their state.
      rd_en  <= 1'b0;
      tx_int <= 1'b0;
      done   <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              rd_addr <= start_addr;
              end_reg <= end_addr;
              lat_cnt <= '0;
              rd_en   <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
              csum    <= '0;
`endif
              state   <= ST_READ;
            end
          end
          ST_READ: begin
            if (lat_cnt == LAT_LAST) state <= ST_CAPTURE;
            else                     lat_cnt <= lat_cnt + LAT_W'(1);
          end
          ST_CAPTURE: begin
            tx_int <= 1'b1;
            state  <= ST_SEND;
          end
          ST_SEND: state <= ST_WAIT;
          ST_WAIT: begin
            if (tx_ok) begin
`ifdef DUMP_CHECKSUM_EN
              csum <= csum + tx_byte;
`endif
              // remaining still shows the pre-shift count here.
              if (remaining == CNT_W'(1)) begin
                state <= ST_NEXT;
              end else begin
                tx_int <= 1'b1;
                state  <= ST_SEND;
              end
            end
          end
          ST_NEXT: begin
            if (rd_addr == end_reg) begin
`ifdef DUMP_CHECKSUM_EN
              tx_int <= 1'b1;
              state  <= ST_CSUM_SEND;
`else
              done   <= 1'b1;
              state  <= ST_DONE;
`endif
            end else begin
              rd_addr <= rd_addr + ADDR_W'(1);
              lat_cnt <= '0;
              rd_en   <= 1'b1;
              state   <= ST_READ;
            end
          end
`ifdef DUMP_CHECKSUM_EN
          ST_CSUM_SEND: state <= ST_CSUM_WAIT;
          ST_CSUM_WAIT: begin
            if (tx_ok) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
`endif
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_dump_tx.sv
// tb_ram_dump_tx: directed bench for ram_dump_tx with three configurations:
//   a: 32-bit LSB-first, RD_LAT=1; b: 48-bit MSB-first; c: ADDR_W=4, RD_LAT=3.
// RAM models drive junk on rd_data except in the exact capture cycle.
module tb_ram_dump_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT a ----------------
  logic        start_a = 0, abort_a = 0, rd_en_a, tx_int_a, tx_ok_a = 0, busy_a, done_a;
  logic [15:0] sa_a = 0, ea_a = 0, rd_addr_a;
  logic [31:0] rd_data_a = 0;
  logic [7:0]  tx_byte_a;
  logic [31:0] mem_a [16];
  logic [4:0]  pa [2] = '{default: '0};
  int          ucnt_a = 0, done_n_a = 0, donec_a = 0;
  byte unsigned q_a[$];
  int          txc_a[$], rdc_a[$];

  ram_dump_tx #(.DATA_W(32), .ADDR_W(16), .RD_LAT(1), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .start_addr(sa_a), .end_addr(ea_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .tx_byte(tx_byte_a),
    .tx_int(tx_int_a), .tx_ok(tx_ok_a), .busy(busy_a), .done(done_a));

  always @(negedge clk) begin
    pa[1] = pa[0];
    pa[0] = {rd_en_a, rd_addr_a[3:0]};
    rd_data_a = pa[1][4] ? mem_a[pa[1][3:0]] : 32'hA5A5_5A5A;
    tx_ok_a = 1'b0;
    if (ucnt_a != 0) begin ucnt_a--; if (ucnt_a == 0) tx_ok_a = 1'b1; end
    if (tx_int_a) begin q_a.push_back(tx_byte_a); txc_a.push_back(cyc); ucnt_a = 10; end
    if (rd_en_a) rdc_a.push_back(cyc);
    if (done_a) begin done_n_a++; donec_a = cyc; end
  end

  // ---------------- DUT b ----------------
  logic        start_b = 0, abort_b = 0, rd_en_b, tx_int_b, tx_ok_b = 0, busy_b, done_b;
  logic [15:0] sa_b = 0, ea_b = 0, rd_addr_b;
  logic [47:0] rd_data_b = 0;
  logic [7:0]  tx_byte_b;
  logic [47:0] mem_b [16];
  logic [4:0]  pb [2] = '{default: '0};
  int          ucnt_b = 0, done_n_b = 0, rden_b = 0;
  byte unsigned q_b[$];

  ram_dump_tx #(.DATA_W(48), .ADDR_W(16), .RD_LAT(1), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .start_addr(sa_b), .end_addr(ea_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .tx_byte(tx_byte_b),
    .tx_int(tx_int_b), .tx_ok(tx_ok_b), .busy(busy_b), .done(done_b));

  always @(negedge clk) begin
    pb[1] = pb[0];
    pb[0] = {rd_en_b, rd_addr_b[3:0]};
    rd_data_b = pb[1][4] ? mem_b[pb[1][3:0]] : 48'hBEEF_DEAD_C0DE;
    tx_ok_b = 1'b0;
    if (ucnt_b != 0) begin ucnt_b--; if (ucnt_b == 0) tx_ok_b = 1'b1; end
    if (tx_int_b) begin q_b.push_back(tx_byte_b); ucnt_b = 10; end
    if (rd_en_b) rden_b++;
    if (done_b) done_n_b++;
  end

  // ---------------- DUT c ----------------
  logic        start_c = 0, abort_c = 0, rd_en_c, tx_int_c, tx_ok_c = 0, busy_c, done_c;
  logic [3:0]  sa_c = 0, ea_c = 0, rd_addr_c;
  logic [31:0] rd_data_c = 0;
  logic [7:0]  tx_byte_c;
  logic [31:0] mem_c [16];
  logic [4:0]  pc [4] = '{default: '0};
  int          ucnt_c = 0, done_n_c = 0;
  byte unsigned q_c[$];
  logic [3:0]  qaddr_c[$];

  ram_dump_tx #(.DATA_W(32), .ADDR_W(4), .RD_LAT(3), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .start_addr(sa_c), .end_addr(ea_c),
    .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c), .tx_byte(tx_byte_c),
    .tx_int(tx_int_c), .tx_ok(tx_ok_c), .busy(busy_c), .done(done_c));

  always @(negedge clk) begin
    for (int k = 3; k > 0; k--) pc[k] = pc[k-1];
    pc[0] = {rd_en_c, rd_addr_c};
    rd_data_c = pc[3][4] ? mem_c[pc[3][3:0]] : 32'h5A5A_A5A5;
    tx_ok_c = 1'b0;
    if (ucnt_c != 0) begin ucnt_c--; if (ucnt_c == 0) tx_ok_c = 1'b1; end
    if (tx_int_c) begin q_c.push_back(tx_byte_c); ucnt_c = 10; end
    if (rd_en_c) qaddr_c.push_back(rd_addr_c);
    if (done_c) done_n_c++;
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Compares the byte stream; with the checksum build the expected sum byte is appended.
  task automatic chk_bytes(input string tag, input byte unsigned got[$], input byte unsigned exp[$]);
`ifdef DUMP_CHECKSUM_EN
    byte unsigned s = 0;
    foreach (exp[i]) s += exp[i];
    exp.push_back(s);
`endif
    chk({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), (i < got.size()) ? 64'(got[i]) : 64'h100, 64'(exp[i]));
  endtask

  task automatic wait_done(input int which, input string tag);
    int   n = 0;
    logic d = 1'b0;
    while (!d && n < 3000) begin
      @(negedge clk);
      n++;
      case (which)
        0:       d = done_a;
        1:       d = done_b;
        default: d = done_c;
      endcase
    end
    chk(tag, 64'(d), 64'd1);
  endtask

  byte unsigned exp[$];
  int sc, d0, n, guard;

  initial begin
    foreach (mem_a[i]) mem_a[i] = 32'h0;
    foreach (mem_b[i]) mem_b[i] = 48'h0;
    foreach (mem_c[i]) mem_c[i] = 32'h0;
    mem_a[0]  = 32'h4433_2211;  mem_a[1] = 32'hDDCC_BBAA;
    mem_b[5]  = 48'h0102_0304_0506;
    mem_c[14] = 32'h0403_0201;  mem_c[15] = 32'h0807_0605;
    mem_c[0]  = 32'h0C0B_0A09;  mem_c[1]  = 32'h100F_0E0D;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 64'(rd_en_a), 0);
    chk("rst_rd_addr", 64'(rd_addr_a), 0);
    chk("rst_tx_byte", 64'(tx_byte_a), 0);
    chk("rst_tx_int", 64'(tx_int_a), 0);
    chk("rst_busy", 64'(busy_a), 0);
    chk("rst_done", 64'(done_a), 0);
    chk("rst_busy_b", 64'(busy_b), 0);
    chk("rst_busy_c", 64'(busy_c), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Two LSB-first words, plus cycle-accurate handshake timing
    q_a.delete(); txc_a.delete(); rdc_a.delete(); d0 = done_n_a;
    sa_a = 16'h0010; ea_a = 16'h0011; start_a = 1'b1; sc = cyc;
    @(negedge clk); start_a = 1'b0;
    wait_done(0, "t1_done_seen");
    @(negedge clk);
    chk("t1_busy_after", 64'(busy_a), 0);
    chk("t1_done_cnt", 64'(done_n_a - d0), 1);
    chk("t1_rden_cnt", 64'(rdc_a.size()), 2);
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    chk_bytes("t1", q_a, exp);
    if (rdc_a.size() >= 1 && txc_a.size() >= 8) begin
      chk("t1_start_to_rden", 64'(rdc_a[0] - sc), 1);
      chk("t1_start_to_txint", 64'(txc_a[0] - sc), 3);
      chk("t1_txok_to_txint", 64'(txc_a[1] - txc_a[0]), 11);
      chk("t1_word_gap", 64'(txc_a[4] - txc_a[3]), 14);
`ifndef DUMP_CHECKSUM_EN
      chk("t1_last_to_done", 64'(donec_a - txc_a[7]), 12);
`endif
    end else begin
      chk("t1_event_count", 64'(txc_a.size()), 8);
    end

    // Abort 3 cycles after the 2nd tx_int, then a clean restart
    q_a.delete(); d0 = done_n_a;
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    n = 0; guard = 0;
    while (n < 2 && guard < 500) begin
      @(negedge clk); guard++;
      if (tx_int_a) n++;
    end
    chk("ab_reach_2nd_txint", 64'(n), 2);
    repeat (3) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk); abort_a = 1'b0;
    chk("ab_busy_low", 64'(busy_a), 0);
    repeat (40) @(negedge clk);
    chk("ab_no_more_txint", 64'(q_a.size()), 2);
    chk("ab_no_done", 64'(done_n_a - d0), 0);
    q_a.delete();
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_done(0, "ab_restart_done");
    @(negedge clk);
    chk_bytes("ab_restart", q_a, exp);
    chk("ab_restart_done_cnt", 64'(done_n_a - d0), 1);

    // MSB-first 48-bit single word; a start while busy is ignored
    q_b.delete(); rden_b = 0; d0 = done_n_b;
    sa_b = 16'h0005; ea_b = 16'h0005; start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    repeat (20) @(negedge clk);
    sa_b = 16'h0000; ea_b = 16'h0003; start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    wait_done(1, "t2_done_seen");
    @(negedge clk);
    chk("t2_rden_cnt", 64'(rden_b), 1);
    chk("t2_done_cnt", 64'(done_n_b - d0), 1);
    chk("t2_busy_after", 64'(busy_b), 0);
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    chk_bytes("t2", q_b, exp);

    // ADDR_W=4 wrap E..1 with RD_LAT=3 and junk outside the capture cycle
    q_c.delete(); qaddr_c.delete(); d0 = done_n_c;
    sa_c = 4'hE; ea_c = 4'h1; start_c = 1'b1;
    @(negedge clk); start_c = 1'b0;
    wait_done(2, "t3_done_seen");
    @(negedge clk);
    chk("t3_addr_cnt", 64'(qaddr_c.size()), 4);
    if (qaddr_c.size() == 4) begin
      chk("t3_addr0", 64'(qaddr_c[0]), 64'hE);
      chk("t3_addr1", 64'(qaddr_c[1]), 64'hF);
      chk("t3_addr2", 64'(qaddr_c[2]), 64'h0);
      chk("t3_addr3", 64'(qaddr_c[3]), 64'h1);
    end
    chk("t3_done_cnt", 64'(done_n_c - d0), 1);
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
            8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};
    chk_bytes("t3", q_c, exp);

`ifdef DUMP_CHECKSUM_EN
    // Checksum: FF + 02 wraps to 01
    mem_a[0] = 32'h0000_00FF; mem_a[1] = 32'h0000_0002;
    q_a.delete();
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_done(0, "cs_done_seen");
    @(negedge clk);
    exp = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    chk_bytes("cs", q_a, exp);
    chk("cs_final_byte", (q_a.size() == 9) ? 64'(q_a[8]) : 64'h100, 64'h01);
`endif

    // Asynchronous reset in the middle of a dump
    sa_c = 4'h3; ea_c = 4'h3; start_c = 1'b1;
    @(negedge clk); start_c = 1'b0;
    repeat (6) @(negedge clk);
    chk("rm_busy_before", 64'(busy_c), 1);
    #2 rst = 1'b1;
    #1;
    chk("rm_busy_async", 64'(busy_c), 0);
    chk("rm_tx_int_async", 64'(tx_int_c), 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
